// File: rtl/conv_wload_pkg.sv
// conv_wload_pkg: shared widths, kernel size and FSM state encoding for the weight loader.
package conv_wload_pkg;
   localparam int DEF_DWIDTH  = 16;
   localparam int DEF_MEMSIZE = 12;
   localparam int DEF_FSIZE   = 5;
   localparam int DEF_NWEIGHT = DEF_FSIZE * DEF_FSIZE;
   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_wload.sv
// conv_wload: streams one FSIZE*FSIZE kernel from weight memory into a shift-register chain.
// Define CONV_WLOAD_BIAS_EN to fetch one extra word per load and hold it on the bias port.
module conv_wload
   import conv_wload_pkg::*;
#(
   parameter int DWIDTH  = DEF_DWIDTH,
   parameter int MEMSIZE = DEF_MEMSIZE,
   parameter int FSIZE   = DEF_FSIZE
) (
   input  logic                      clk,
   input  logic                      xrst,
   input  logic                      start,
   input  logic [MEMSIZE-1:0]        base_addr,
   input  logic signed [DWIDTH-1:0]  mem_rdata,
   output logic                      mem_re,
   output logic [MEMSIZE-1:0]        mem_addr,
   output logic signed [DWIDTH-1:0]  read_data,
   output logic                      wreg_we,
`ifdef CONV_WLOAD_BIAS_EN
   output logic signed [DWIDTH-1:0]  bias,
`endif
   output logic                      busy,
   output logic                      done
);
   localparam int NWEIGHT = FSIZE * FSIZE;
`ifdef CONV_WLOAD_BIAS_EN
   localparam int NREAD = NWEIGHT + 1;
`else
   localparam int NREAD = NWEIGHT;
`endif
   localparam int CW = $clog2(NREAD + 1);
   localparam logic [CW-1:0] LAST = CW'(NREAD - 1);
   localparam logic [CW-1:0] WEND = CW'(NWEIGHT);
   state_t state, state_nx;
   logic [MEMSIZE-1:0] base;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge xrst)
      if (!xrst) begin
         state   <= IDLE;
         base    <= '0;
         cnt     <= '0;
         wreg_we <= 1'b0;
      end else begin
         state   <= state_nx;
         wreg_we <= mem_re && cnt != WEND;
         if (state == IDLE && start) begin
            base <= base_addr;
            cnt  <= '0;
         end else if (state == FETCH) cnt <= cnt + 1'b1;
      end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? FETCH : IDLE;
         FETCH:   state_nx = cnt == LAST ? DRAIN : FETCH;
         DRAIN:   state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   assign mem_re    = state == FETCH;
   assign mem_addr  = mem_re ? base + MEMSIZE'(cnt) : '0;
   assign read_data = wreg_we ? mem_rdata : '0;
   assign busy      = state == FETCH || state == DRAIN;
   assign done      = state == DONE;
`ifdef CONV_WLOAD_BIAS_EN
   // The word after the kernel lands one cycle after its read, in DRAIN.
   logic bias_cap;
   always_ff @(posedge clk or negedge xrst)
      if (!xrst) begin
         bias_cap <= 1'b0;
         bias     <= '0;
      end else begin
         bias_cap <= mem_re && cnt == WEND;
         if (bias_cap) bias <= mem_rdata;
      end
`endif
endmodule

// File: tb/tb_conv_wload.sv
// tb_conv_wload: directed bench for conv_wload with an addr+100 weight memory and chain model.
module tb_conv_wload;
`ifdef CONV_WLOAD_BIAS_EN
   localparam int NR = 26;
   localparam int LAT = 28;
`else
   localparam int NR = 25;
   localparam int LAT = 27;
`endif
   logic clk = 1'b0, xrst = 1'b0, start = 1'b0;
   logic [11:0] base_addr = '0;
   logic signed [15:0] mem_rdata = '0;
   logic mem_re, wreg_we, busy, done;
   logic [11:0] mem_addr;
   logic signed [15:0] read_data;
`ifdef CONV_WLOAD_BIAS_EN
   logic signed [15:0] bias;
`endif
   int tests = 0, fails = 0, n_we = 0;
   logic [15:0] chain [25];
   conv_wload dut (
      .clk(clk), .xrst(xrst), .start(start), .base_addr(base_addr), .mem_rdata(mem_rdata),
      .mem_re(mem_re), .mem_addr(mem_addr), .read_data(read_data), .wreg_we(wreg_we),
`ifdef CONV_WLOAD_BIAS_EN
      .bias(bias),
`endif
      .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) mem_rdata <= mem_re ? 16'(mem_addr) + 16'sd100 : 16'sd0;
   always @(posedge clk)
      if (wreg_we) begin
         n_we++;
         for (int i = 0; i < 24; i++) chain[i] = chain[i+1];
         chain[24] = read_data;
      end
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic run_load(input logic [11:0] b, input bit inj);
      logic [11:0] a, wa;
      bit we;
      int we0;
      we0 = n_we;
      base_addr = b;
      start = 1'b1;
      for (int c = 1; c <= LAT; c++) begin
         tick;
         start = inj && (c == 5 || c == 20);
         a  = b + 12'(c - 1);
         wa = b + 12'(c - 2);
         we = c >= 2 && c <= 26;
         check("mem_re", 32'(mem_re), 32'(c <= NR));
         check("mem_addr", 32'(mem_addr), c <= NR ? 32'(a) : 32'd0);
         check("wreg_we", 32'(wreg_we), 32'(we));
         check("read_data", 32'(read_data), we ? 32'(wa) + 32'd100 : 32'd0);
         check("busy", 32'(busy), 32'(c < LAT));
         check("done", 32'(done), 32'(c == LAT));
      end
      check("we_count", 32'(n_we - we0), 32'd25);
      check("chain0", 32'(chain[0]), 32'(b) + 32'd100);
      check("chain24", 32'(chain[24]), 32'(12'(b + 12'd24)) + 32'd100);
`ifdef CONV_WLOAD_BIAS_EN
      check("bias", 32'(bias), 32'(12'(b + 12'd25)) + 32'd100);
`endif
   endtask
   initial begin
      int we0;
      repeat (3) tick;
      check("rst_mem_re", 32'(mem_re), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      check("rst_wreg_we", 32'(wreg_we), 32'd0);
      check("rst_read_data", 32'(read_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
`ifdef CONV_WLOAD_BIAS_EN
      check("rst_bias", 32'(bias), 32'd0);
`endif
      xrst = 1'b1;
      repeat (2) tick;
      run_load(12'h010, 1'b0);
      tick;
      run_load(12'hFF0, 1'b0);
      tick;
      run_load(12'h200, 1'b1);
      base_addr = 12'h300;
      start = 1'b1;
      tick;
      start = 1'b0;
      check("done_start_ign_re", 32'(mem_re), 32'd0);
      check("done_start_ign_busy", 32'(busy), 32'd0);
      run_load(12'h040, 1'b0);
      tick;
      base_addr = 12'h100;
      start = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick;
         start = 1'b0;
      end
      check("mid_busy", 32'(busy), 32'd1);
      xrst = 1'b0;
      #1;
      check("abort_mem_re", 32'(mem_re), 32'd0);
      check("abort_mem_addr", 32'(mem_addr), 32'd0);
      check("abort_wreg_we", 32'(wreg_we), 32'd0);
      check("abort_read_data", 32'(read_data), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      we0 = n_we;
      repeat (3) tick;
      xrst = 1'b1;
      repeat (4) tick;
      check("abort_no_we", 32'(n_we - we0), 32'd0);
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_idle_re", 32'(mem_re), 32'd0);
      run_load(12'h123, 1'b0);
      tick;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
